// File: rtl/frame_asm_pkg.sv
// Shared types and constants for the per-agent frame assembler.
package frame_asm_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_TRL} fa_state_e;

  localparam logic [7:0] HDR_SYNC    = 8'hA5;
  localparam logic [7:0] TRL_SYNC    = 8'h5A;
  localparam int         BUF_ENTRIES = 4;

  // Default-width buffer entry; the top re-declares it at DATA_WIDTH.
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } buf_ent_t;

  function automatic logic [15:0] fold16(input logic [31:0] d);
    return d[31:16] ^ d[15:0];
  endfunction

endpackage

// File: rtl/frame_prefetch_buf.sv
// Small prefetch FIFO of {sop, eop, data} entries between the agent FIFO and the framer.
module frame_prefetch_buf
  import frame_asm_pkg::*;
#(
  parameter int  DEPTH = BUF_ENTRIES,
  parameter type ent_t = buf_ent_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst,
  input  logic             push,
  input  ent_t             din,
  input  logic             pop,
  output ent_t             head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  ent_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;

  assign w_pop  = pop && (r_cnt != '0);
  assign w_push = push && ((r_cnt != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (sw_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

  assign head  = r_mem[r_rp];
  assign count = r_cnt;
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/frame_assembler.sv
// Drains committed packets from an agent FIFO and emits header / payload / trailer frames.
module frame_assembler
  import frame_asm_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] AGENT_ID   = 8'h00,
  parameter int         BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst,
  input  logic                  pkt_commit,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_sop,
  input  logic                  fifo_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  err_frame,
  output logic [15:0]           seq_num
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  ent_t                  w_in, w_head;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_empty, w_pop, w_pay_eop;
  logic [DATA_WIDTH-1:0] w_hdr, w_trl;

  logic                  r_inflight;
  fa_state_e             r_state;
  logic [5:0]            r_pend;
  logic [15:0]           r_seq;
  logic [6:0]            r_wcnt;
  logic [15:0]           r_csum;
  logic                  r_first;
  logic                  r_err;

  // At most one read in flight keeps the buffer at <= 3 entries, leaving headroom.
  assign fifo_rd_en = !fifo_empty && ((int'(w_cnt) + int'(r_inflight)) <= (BUF_DEPTH - 2));

  assign w_in = '{sop: fifo_sop, eop: fifo_eop, data: fifo_rd_data};

  frame_prefetch_buf #(
    .DEPTH (BUF_DEPTH),
    .ent_t (ent_t)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_rst(sw_rst),
    .push  (r_inflight),
    .din   (w_in),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_cnt),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_inflight <= 1'b0;
    else if (sw_rst) r_inflight <= 1'b0;
    else             r_inflight <= fifo_rd_en;
  end

  assign w_hdr = DATA_WIDTH'({HDR_SYNC, AGENT_ID, r_seq});
  assign w_trl = DATA_WIDTH'({TRL_SYNC, 1'b0, r_wcnt, r_csum});

  // Outputs decode registered state only, so nothing here depends on out_ready.
  always_comb begin
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    out_data  = '0;
    case (r_state)
      ST_HDR: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_data  = w_hdr;
      end
      ST_PAYLOAD: begin
        out_valid = !w_empty;
        out_data  = w_head.data;
      end
      ST_TRL: begin
        out_valid = 1'b1;
        out_eof   = 1'b1;
        out_data  = w_trl;
      end
      default: ;
    endcase
  end

  assign w_pop     = (r_state == ST_PAYLOAD) && out_valid && out_ready;
  assign w_pay_eop = w_pop && w_head.eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pend <= '0;
    else if (sw_rst) r_pend <= '0;
    else begin
      case ({pkt_commit, w_pay_eop})
        2'b10:   if (r_pend != '1) r_pend <= r_pend + 1'b1;
        2'b01:   if (r_pend != '0) r_pend <= r_pend - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_wcnt  <= '0;
      r_csum  <= '0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else if (sw_rst) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_wcnt  <= '0;
      r_csum  <= '0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (r_pend != '0) r_state <= ST_HDR;
        ST_HDR: if (out_ready) begin
          r_state <= ST_PAYLOAD;
          r_wcnt  <= '0;
          r_csum  <= '0;
          r_first <= 1'b1;
        end
        ST_PAYLOAD: if (w_pop) begin
          r_wcnt  <= r_wcnt + 1'b1;
          r_csum  <= r_csum ^ fold16(w_head.data[31:0]);
          r_first <= 1'b0;
          // Misplaced sop is flagged but the word still goes out.
          r_err   <= r_first ? !w_head.sop : w_head.sop;
          if (w_head.eop) r_state <= ST_TRL;
        end
        ST_TRL: if (out_ready) begin
          r_seq   <= r_seq + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign err_frame = r_err;
  assign seq_num   = r_seq;

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench: FIFO model feeding frame_assembler, output capture and stall monitoring.
module tb_frame_assembler;
  localparam int DW = 32;

  logic          clk = 1'b0, rst_n = 1'b0, sw_rst = 1'b0, pkt_commit = 1'b0;
  logic          fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_sop = 1'b0, fifo_eop = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready = 1'b1, out_sof, out_eof, err_frame;
  logic [15:0]   seq_num;

  always #5 clk = ~clk;

  frame_assembler #(.DATA_WIDTH(DW), .AGENT_ID(8'h07), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .pkt_commit(pkt_commit),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_sop(fifo_sop), .fifo_eop(fifo_eop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof), .err_frame(err_frame),
    .seq_num(seq_num)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Agent FIFO model with 1-cycle read latency; a soft reset also empties it.
  logic [DW+1:0] fmem [256];
  logic [7:0]    wp = '0, rp = '0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (sw_rst) rp <= wp;
    else if (fifo_rd_en) begin
      {fifo_sop, fifo_eop, fifo_rd_data} <= fmem[rp];
      rp <= rp + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW+1:0] cap [$];
  logic [DW+1:0] ex [$];
  int            hdr_cyc [$];
  int            n_eof = 0, n_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_out = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("stall_stable", {out_sof, out_eof, out_data}, prev_out);
      if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 1'b0);
      chk("buf_cnt_le4", dut.w_cnt <= 3'd4, 1'b1);
      if (out_valid && out_ready) begin
        cap.push_back({out_sof, out_eof, out_data});
        if (out_sof) hdr_cyc.push_back(cyc);
        if (out_eof) n_eof++;
      end
      if (err_frame) n_err++;
    end
    prev_stall <= rst_n && out_valid && !out_ready && !sw_rst;
    prev_out   <= {out_sof, out_eof, out_data};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic sop, input logic eop, input logic [DW-1:0] d);
    fmem[wp] = {sop, eop, d};
    wp = wp + 8'd1;
  endtask

  task automatic commit(output int c0);
    step();
    pkt_commit = 1'b1;
    c0 = cyc;
    step();
    pkt_commit = 1'b0;
  endtask

  task automatic wait_eof(input int target, input bit tog);
    int k = 0;
    while (n_eof < target && k < 300) begin
      step();
      if (tog) out_ready = ~out_ready;
      k++;
    end
    chk("frame_timeout", n_eof >= target, 1'b1);
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_len"}, cap.size(), ex.size());
    foreach (ex[i]) if (i < cap.size()) chk($sformatf("%s_w%0d", tag, i), cap[i], ex[i]);
  endtask

  initial begin
    int c0, b, e0, k;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_seq", seq_num, 16'h0000);
    chk("rst_flags", {out_sof, out_eof, err_frame}, 3'b000);
    chk("rst_data", out_data, 32'h0);
    rst_n = 1'b1;
    step();

    // Single 3-word frame: csum = 0000 ^ 2222 ^ FFFF = DDDD.
    cap.delete(); hdr_cyc.delete(); b = n_eof;
    push_word(1'b1, 1'b0, 32'h11111111);
    push_word(1'b0, 1'b0, 32'h22220000);
    push_word(1'b0, 1'b1, 32'h0000FFFF);
    commit(c0);
    wait_eof(b + 1, 1'b0);
    ex = '{{2'b10, 32'hA5070000}, {2'b00, 32'h11111111}, {2'b00, 32'h22220000},
           {2'b00, 32'h0000FFFF}, {2'b01, 32'h5A03DDDD}};
    check_cap("single");
    chk("hdr_latency", (hdr_cyc.size() > 0) ? hdr_cyc[0] - c0 : -1, 2);
    chk("seq_single", seq_num, 16'h0001);

    // Back-to-back 1-word packets.
    cap.delete(); b = n_eof;
    push_word(1'b1, 1'b1, 32'h0000ABCD);
    push_word(1'b1, 1'b1, 32'h0000ABCD);
    commit(c0);
    commit(c0);
    wait_eof(b + 2, 1'b0);
    ex = '{{2'b10, 32'hA5070001}, {2'b00, 32'h0000ABCD}, {2'b01, 32'h5A01ABCD},
           {2'b10, 32'hA5070002}, {2'b00, 32'h0000ABCD}, {2'b01, 32'h5A01ABCD}};
    check_cap("b2b");
    chk("pend_zero", dut.r_pend, 6'd0);
    chk("seq_b2b", seq_num, 16'h0003);

    // Backpressure: csum = 444C ^ 444C ^ 0000 ^ 7040 = 7040.
    cap.delete(); b = n_eof;
    push_word(1'b1, 1'b0, 32'h12345678);
    push_word(1'b0, 1'b0, 32'h9ABCDEF0);
    push_word(1'b0, 1'b0, 32'h0F0F0F0F);
    push_word(1'b0, 1'b1, 32'hCAFEBABE);
    commit(c0);
    wait_eof(b + 1, 1'b1);
    ex = '{{2'b10, 32'hA5070003}, {2'b00, 32'h12345678}, {2'b00, 32'h9ABCDEF0},
           {2'b00, 32'h0F0F0F0F}, {2'b00, 32'hCAFEBABE}, {2'b01, 32'h5A047040}};
    check_cap("bp");

    // First payload word without sop: one error pulse, frame completes.
    cap.delete(); b = n_eof; e0 = n_err;
    push_word(1'b0, 1'b0, 32'h00010002);
    push_word(1'b0, 1'b1, 32'h00030004);
    commit(c0);
    wait_eof(b + 1, 1'b0);
    ex = '{{2'b10, 32'hA5070004}, {2'b00, 32'h00010002}, {2'b00, 32'h00030004},
           {2'b01, 32'h5A020004}};
    check_cap("ferr");
    chk("err_pulses", n_err - e0, 1);

    // Soft reset after two of five payload words.
    cap.delete(); b = n_eof;
    for (int i = 1; i <= 5; i++) push_word(i == 1, i == 5, 32'hA0000000 + i);
    commit(c0);
    k = 0;
    while (cap.size() < 3 && k < 50) begin step(); k++; end
    chk("swrst_reach", cap.size(), 3);
    sw_rst = 1'b1; out_ready = 1'b0;
    step();
    sw_rst = 1'b0;
    chk("swrst_valid", out_valid, 1'b0);
    chk("swrst_seq", seq_num, 16'h0000);
    chk("swrst_pend", dut.r_pend, 6'd0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("swrst_no_trailer", n_eof, b);
    cap.delete(); b = n_eof;
    push_word(1'b1, 1'b1, 32'h00050003);
    commit(c0);
    wait_eof(b + 1, 1'b0);
    ex = '{{2'b10, 32'hA5070000}, {2'b00, 32'h00050003}, {2'b01, 32'h5A010006}};
    check_cap("post_swrst");

    // Sequence wrap from FFFF.
    force dut.r_seq = 16'hFFFF;
    step();
    release dut.r_seq;
    step();
    chk("seq_preload", seq_num, 16'hFFFF);
    cap.delete(); b = n_eof;
    push_word(1'b1, 1'b1, 32'h00000001);
    commit(c0);
    wait_eof(b + 1, 1'b0);
    push_word(1'b1, 1'b1, 32'h00000002);
    commit(c0);
    wait_eof(b + 2, 1'b0);
    ex = '{{2'b10, 32'hA507FFFF}, {2'b00, 32'h00000001}, {2'b01, 32'h5A010001},
           {2'b10, 32'hA5070000}, {2'b00, 32'h00000002}, {2'b01, 32'h5A010002}};
    check_cap("wrap");
    chk("seq_wrap", seq_num, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
